// File: rtl/ahb_core_req_gen.sv
// Core-side request generator for the AHB master port: packs core load/store requests into
// command words, tracks them in an in-order tag queue and returns lane-extracted responses.
module ahb_core_req_gen #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic [66:0] datain,
  output logic        core_writen,
  output logic        core_readen,
  input  logic        valid,
  input  logic        error,
  input  logic [31:0] rdata
);

  localparam int unsigned CntW = TAG_W + 1;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic [1:0] addr_lo;
    logic       sgn;
    logic       lerr;
  } tag_t;

  typedef enum logic [1:0] {StIdle, StHead, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_error_q, rsp_error_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [66:0]     datain_q, datain_d;
  logic            core_writen_q, core_writen_d;
  tag_t            tag_q [MAX_OUT];
  tag_t            tag_d, head;
  logic            mis, push, pop;
  logic [31:0]     wdata_rep;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                          input logic [1:0] a, input logic sg);
    logic [31:0] sh;
    logic [15:0] h;
    sh = d >> {a, 3'b000};
    h  = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'd0:    return {{24{sg & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{sg & h[15]}}, h};
      default: return d;
    endcase
  endfunction

  assign head = tag_q[rd_ptr_q];

  // Request side: accept, misalign check, command packing.
  always_comb begin
    mis = (req_size == 2'd3) ||
          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) ||
          ((req_size == 2'd1) && req_addr[0]);
    push = req_valid & req_ready_q;

    tag_d.write   = req_write;
    tag_d.size    = req_size;
    tag_d.addr_lo = req_addr[1:0];
    tag_d.sgn     = req_signed;
    tag_d.lerr    = mis;

    case (req_size)
      2'd0:    wdata_rep = {4{req_wdata[7:0]}};
      2'd1:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase

    core_writen_d = push & ~mis;
    datain_d      = (push & ~mis) ? {req_write, req_size, req_addr, wdata_rep} : datain_q;
  end

  // Response FSM.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    core_readen = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StHead;
      end
      StHead: begin
        if (head.lerr) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = StHold;
        end else if (valid && !HRESET) begin
          core_readen = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = error;
          rsp_rdata_d = (error || head.write) ? 32'h0 :
                        extract(rdata, head.size, head.addr_lo, head.sgn);
          state_d     = StHold;
        end
      end
      StHold: begin
        if (rsp_ready) begin
          pop         = 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = ((count_q > CntW'(1)) || push) ? StHead : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    count_d  = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d = wr_ptr_q + TAG_W'(push);
    rd_ptr_d = rd_ptr_q + TAG_W'(pop);
    // A pop only frees a slot for the following cycle since req_ready is registered.
    req_ready_d = (count_d < CntW'(MAX_OUT));
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= StIdle;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      datain_q      <= '0;
      core_writen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
      datain_q      <= datain_d;
      core_writen_q <= core_writen_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) tag_q[wr_ptr_q] <= tag_d;
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign datain      = datain_q;
  assign core_writen = core_writen_q;

  // The master must not present a response with nothing to match it against.
  assert property (@(posedge HCLK) disable iff (HRESET)
    !(valid && ((count_q == '0) || ((state_q == StHead) && head.lerr))));

endmodule

// File: tb/tb_ahb_core_req_gen.sv
// Directed bench for ahb_core_req_gen: stores, lane-extracted loads, misalign, back-pressure, reset.
module tb_ahb_core_req_gen;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_error, core_writen, core_readen;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [66:0] datain;
  logic        valid = 1'b0, error = 1'b0;
  logic [31:0] rdata = '0;

  int total = 0;
  int bad   = 0;
  int seen;

  ahb_core_req_gen #(.MAX_OUT(4), .TAG_W(2)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_error   (rsp_error),
    .rsp_rdata   (rsp_rdata),
    .datain      (datain),
    .core_writen (core_writen),
    .core_readen (core_readen),
    .valid       (valid),
    .error       (error),
    .rdata       (rdata)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
  endtask

  // Returns at the negedge right after the accepting posedge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    bit ok = 0;
    set_req(w, sz, sg, a, wd);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge HCLK);
    end
    if (!ok) chk("req_ready_timeout", {66'd0, req_ready}, 67'd1);
    @(negedge HCLK);
    req_valid = 1'b0;
  endtask

  task automatic master_rsp(input logic err, input logic [31:0] d, output int n);
    n = 0;
    valid = 1'b1; error = err; rdata = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (core_readen) begin n = 1; break; end
      @(negedge HCLK);
    end
    if (n == 1) @(negedge HCLK);
    else chk("core_readen_timeout", {66'd0, core_readen}, 67'd1);
    valid = 1'b0; error = 1'b0; rdata = '0;
  endtask

  task automatic rsp_take(input string tag, input logic err, input logic [31:0] d);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge HCLK);
    end
    chk({tag, "_valid"}, {66'd0, rsp_valid}, 67'd1);
    chk({tag, "_error"}, {66'd0, rsp_error}, {66'd0, err});
    chk({tag, "_rdata"}, {35'd0, rsp_rdata}, {35'd0, d});
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, {66'd0, rsp_valid}, 67'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge HCLK);
    chk("rst_req_ready", {66'd0, req_ready}, 67'd0);
    chk("rst_rsp_valid", {66'd0, rsp_valid}, 67'd0);
    chk("rst_writen", {66'd0, core_writen}, 67'd0);
    chk("rst_readen", {66'd0, core_readen}, 67'd0);
    chk("rst_datain", datain, 67'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("post_rst_ready", {66'd0, req_ready}, 67'd1);

    // Word store
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF);
    chk("sw_writen", {66'd0, core_writen}, 67'd1);
    chk("sw_datain", datain, {1'b1, 2'd2, 32'h1000, 32'hDEADBEEF});
    @(negedge HCLK);
    chk("sw_writen_1cyc", {66'd0, core_writen}, 67'd0);
    master_rsp(1'b0, 32'hFFFF_FFFF, seen);
    chk("sw_readen_once", {66'd0, core_readen}, 67'd0);
    rsp_take("sw", 1'b0, 32'h0);

    // Byte loads, lane 3, signed then unsigned
    do_req(1'b0, 2'd0, 1'b1, 32'h2003, 32'h0);
    chk("lb_datain", datain, {1'b0, 2'd0, 32'h2003, 32'h0});
    master_rsp(1'b0, 32'h80FF_FF7F, seen);
    rsp_take("lbs", 1'b0, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h2003, 32'h0);
    master_rsp(1'b0, 32'h80FF_FF7F, seen);
    rsp_take("lbu", 1'b0, 32'h0000_0080);

    // Misaligned half load then aligned upper-half signed load
    do_req(1'b0, 2'd1, 1'b0, 32'h3001, 32'h0);
    chk("mis_no_writen", {66'd0, core_writen}, 67'd0);
    rsp_take("mis", 1'b1, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h3002, 32'h0);
    chk("lh_writen", {66'd0, core_writen}, 67'd1);
    master_rsp(1'b0, 32'h8001_1234, seen);
    rsp_take("lhs", 1'b0, 32'hFFFF_8001);

    // Byte store lane replication
    do_req(1'b1, 2'd0, 1'b0, 32'h5001, 32'h1234_565A);
    chk("sb_datain", datain, {1'b1, 2'd0, 32'h5001, 32'h5A5A_5A5A});
    master_rsp(1'b0, 32'h0, seen);
    rsp_take("sb", 1'b0, 32'h0);

    // Five requests with no response consumption
    set_req(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
    @(negedge HCLK);
    set_req(1'b0, 2'd2, 1'b0, 32'h6002, 32'h0);
    chk("q1_writen", {66'd0, core_writen}, 67'd1);
    chk("q1_datain", datain, {1'b0, 2'd2, 32'h6000, 32'h0});
    @(negedge HCLK);
    set_req(1'b0, 2'd0, 1'b0, 32'h6001, 32'h0);
    chk("q2_no_writen", {66'd0, core_writen}, 67'd0);
    @(negedge HCLK);
    set_req(1'b1, 2'd1, 1'b0, 32'h6004, 32'h0000_BEEF);
    chk("q3_writen", {66'd0, core_writen}, 67'd1);
    chk("q3_datain", datain, {1'b0, 2'd0, 32'h6001, 32'h0});
    @(negedge HCLK);
    set_req(1'b1, 2'd2, 1'b0, 32'h7000, 32'h0BAD_F00D);
    chk("q4_writen_b2b", {66'd0, core_writen}, 67'd1);
    chk("q4_datain", datain, {1'b1, 2'd1, 32'h6004, 32'hBEEF_BEEF});
    chk("full_ready", {66'd0, req_ready}, 67'd0);
    @(negedge HCLK);
    chk("q5_held_writen", {66'd0, core_writen}, 67'd0);
    chk("full_ready_2", {66'd0, req_ready}, 67'd0);
    master_rsp(1'b0, 32'h1122_3344, seen);
    rsp_take("q1", 1'b0, 32'h1122_3344);
    chk("freed_ready", {66'd0, req_ready}, 67'd1);
    @(negedge HCLK);
    req_valid = 1'b0;
    chk("q5_writen", {66'd0, core_writen}, 67'd1);
    chk("q5_datain", datain, {1'b1, 2'd2, 32'h7000, 32'h0BAD_F00D});
    rsp_take("q2", 1'b1, 32'h0);
    master_rsp(1'b0, 32'hAABB_CCDD, seen);
    rsp_take("q3", 1'b0, 32'h0000_00CC);
    master_rsp(1'b0, 32'h1234_5678, seen);
    rsp_take("q4", 1'b0, 32'h0);
    master_rsp(1'b0, 32'h0, seen);
    rsp_take("q5", 1'b0, 32'h0);

    // Master error on word load
    do_req(1'b0, 2'd2, 1'b0, 32'h8000, 32'h0);
    master_rsp(1'b1, 32'hDEAD_0000, seen);
    chk("err_readen_seen", seen, 67'd1);
    chk("err_readen_once", {66'd0, core_readen}, 67'd0);
    rsp_take("err", 1'b1, 32'h0);

    // Reset with three in flight
    do_req(1'b0, 2'd2, 1'b0, 32'h9000, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h9004, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h9008, 32'h0);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("mrst_req_ready", {66'd0, req_ready}, 67'd0);
    chk("mrst_rsp_valid", {66'd0, rsp_valid}, 67'd0);
    chk("mrst_rsp_error", {66'd0, rsp_error}, 67'd0);
    chk("mrst_rsp_rdata", {35'd0, rsp_rdata}, 67'd0);
    chk("mrst_datain", datain, 67'd0);
    chk("mrst_writen", {66'd0, core_writen}, 67'd0);
    chk("mrst_readen", {66'd0, core_readen}, 67'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("mrst_ready_back", {66'd0, req_ready}, 67'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'hA000, 32'h0102_0304);
    chk("fresh_writen", {66'd0, core_writen}, 67'd1);
    chk("fresh_datain", datain, {1'b1, 2'd2, 32'hA000, 32'h0102_0304});
    master_rsp(1'b0, 32'h0, seen);
    rsp_take("fresh", 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
